// File: rtl/pll_pkg.sv
// Shared constants and the FSM state type for the fractional-N sigma-delta modulator.
package pll_pkg;

    localparam int          PLL_FRAC_W  = 16;
    localparam logic [5:0]  PLL_DIV_RST = 6'd16;
    localparam logic [5:0]  PLL_DIV_MIN = 6'd2;

    localparam logic [14:0] LFSR_SEED   = 15'h0001;
    // Feedback taps for x^15 + x^14 + 1 in a left-shifting register.
    localparam logic [14:0] LFSR_TAPS   = 15'h6000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } sdm_state_e;

    function automatic logic [14:0] lfsr_step(input logic [14:0] s);
        return {s[13:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sdm_acc.sv
// First-order accumulator stage: wrap-around sum plus overflow carry.
module sdm_acc #(
    parameter int W = 16
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] add_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W:0] full_s;

    assign full_s  = {1'b0, acc_i} + {1'b0, add_i} + {{W{1'b0}}, cin_i};
    assign sum_o   = full_s[W-1:0];
    assign carry_o = full_s[W];

endmodule

// File: rtl/frac_n_sdm.sv
// MASH 1-1-1 fractional-N modulator producing one clamped division ratio per
// feedback clock, with shadowed configuration and optional LFSR dither.
module frac_n_sdm
    import pll_pkg::*;
#(
    parameter int         FRAC_W  = PLL_FRAC_W,
    parameter logic [5:0] DIV_RST = PLL_DIV_RST,
    parameter logic [5:0] DIV_MIN = PLL_DIV_MIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dither_en,
    input  logic              cfg_load,
    input  logic [5:0]        n_int,
    input  logic [FRAC_W-1:0] n_frac,
    output logic [5:0]        div_n,
    output logic              div_n_vld,
    output logic              sat
);

    sdm_state_e         state_q, state_d;
    logic [5:0]         int_q;
    logic [FRAC_W-1:0]  frac_q;
    logic [FRAC_W-1:0]  acc1_q, acc2_q, acc3_q;
    logic [FRAC_W-1:0]  sum1_s, sum2_s, sum3_s;
    logic               car1_s, car2_s, car3_s;
    logic               c1_q, c2_q, c3_q, c2_d1_q, c3_d1_q, c3_d2_q;
    logic [14:0]        lfsr_q;
    logic [5:0]         div_q, div_d;
    logic               vld_q, sat_q;
    logic               integ_s, dith_s, clamp_s;
    logic signed [3:0]  off_s;
    logic signed [7:0]  target_s;

    assign integ_s = en && ((state_q == ST_PRIME) || (state_q == ST_RUN));
    assign dith_s  = dither_en & lfsr_q[0];

    sdm_acc #(.W(FRAC_W)) u_acc1 (.acc_i(acc1_q), .add_i(frac_q), .cin_i(dith_s),
                                  .sum_o(sum1_s), .carry_o(car1_s));
    sdm_acc #(.W(FRAC_W)) u_acc2 (.acc_i(acc2_q), .add_i(sum1_s), .cin_i(1'b0),
                                  .sum_o(sum2_s), .carry_o(car2_s));
    sdm_acc #(.W(FRAC_W)) u_acc3 (.acc_i(acc3_q), .add_i(sum2_s), .cin_i(1'b0),
                                  .sum_o(sum3_s), .carry_o(car3_s));

    // Next FSM state.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = en ? ST_PRIME : ST_IDLE;
            ST_PRIME: state_d = en ? ST_RUN   : ST_IDLE;
            ST_RUN:   state_d = en ? ST_RUN   : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Noise-shaped offset (mod-16 arithmetic equals the signed result) and clamping.
    always_comb begin
        off_s = 4'sd0;
        if ((state_q == ST_RUN) && en) begin
            off_s = {3'b000, c1_q} + {3'b000, c2_q} - {3'b000, c2_d1_q}
                  + {3'b000, c3_q} - {2'b00, c3_d1_q, 1'b0} + {3'b000, c3_d2_q};
        end else begin
            off_s = 4'sd0;
        end
        target_s = $signed({2'b00, int_q}) + {{4{off_s[3]}}, off_s};
        if (target_s > 8'sd63) begin
            div_d   = 6'd63;
            clamp_s = 1'b1;
        end else if (target_s < $signed({2'b00, DIV_MIN})) begin
            div_d   = DIV_MIN;
            clamp_s = 1'b1;
        end else begin
            div_d   = target_s[5:0];
            clamp_s = 1'b0;
        end
    end

    // All sequential state; IDLE (or en low) flushes the modulator history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            int_q   <= DIV_RST;
            frac_q  <= {FRAC_W{1'b0}};
            acc1_q  <= {FRAC_W{1'b0}};
            acc2_q  <= {FRAC_W{1'b0}};
            acc3_q  <= {FRAC_W{1'b0}};
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            c3_q    <= 1'b0;
            c2_d1_q <= 1'b0;
            c3_d1_q <= 1'b0;
            c3_d2_q <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            div_q   <= DIV_RST;
            vld_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_load) begin
                int_q  <= n_int;
                frac_q <= n_frac;
            end
            if (integ_s) begin
                acc1_q  <= sum1_s;
                acc2_q  <= sum2_s;
                acc3_q  <= sum3_s;
                c1_q    <= car1_s;
                c2_q    <= car2_s;
                c3_q    <= car3_s;
                c2_d1_q <= c2_q;
                c3_d1_q <= c3_q;
                c3_d2_q <= c3_d1_q;
                if (dither_en) begin
                    lfsr_q <= lfsr_step(lfsr_q);
                end
            end else begin
                acc1_q  <= {FRAC_W{1'b0}};
                acc2_q  <= {FRAC_W{1'b0}};
                acc3_q  <= {FRAC_W{1'b0}};
                c1_q    <= 1'b0;
                c2_q    <= 1'b0;
                c3_q    <= 1'b0;
                c2_d1_q <= 1'b0;
                c3_d1_q <= 1'b0;
                c3_d2_q <= 1'b0;
                lfsr_q  <= LFSR_SEED;
            end
            div_q <= div_d;
            vld_q <= (state_d == ST_RUN);
            if (cfg_load) begin
                sat_q <= 1'b0;
            end else if (clamp_s) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign div_n     = div_q;
    assign div_n_vld = vld_q;
    assign sat       = sat_q;

endmodule
